sm_ldst_unit: RTL and testbench

SM-side responder for the per-thread load/store requests issued by the four SP cores. It serializes up to four lane accesses per warp instruction onto one single-port, sync-read data BRAM and stalls the SM pipeline while it does so. It returns per-lane load data timed for each SP core's WB-stage mux, which consumes it combinationally one cycle after the MEM stage.

---
 rtl/sm_ldst_unit_if.sv | 13 +
 rtl/sm_ldst_unit.sv | 140 ++++++++++++++
 tb/tb_sm_ldst_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sm_ldst_unit_if.sv
// rtl/sm_ldst_unit_if.sv - single-port sync-read data BRAM port bundle
interface sm_ldst_unit_if #(
  parameter int ADDR_W = 10
);
  logic              en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wdata;
  logic [15:0]       rdata;

  modport master (output en, output we, output addr, output wdata, input rdata);
  modport slave  (input en, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/sm_ldst_unit.sv
// rtl/sm_ldst_unit.sv - serializes up to four SP lane loads/stores onto one data BRAM
module sm_ldst_unit #(
  parameter int ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           lane_is_load,
  input  logic [3:0]           lane_is_store,
  input  logic [3:0]           lane_active,
  input  logic [63:0]          lane_addr,
  input  logic [63:0]          lane_wdata,
  input  logic                 other_stall,
  output logic                 mem_stall,
  output logic [63:0]          lane_rdata,
  sm_ldst_unit_if.master       dmem
);

  typedef enum logic [1:0] {IDLE, SERVE, DONE} state_t;

  state_t      state;
  logic [3:0]  pending;
  logic [3:0]  batch_ld;
  logic [3:0]  wb_byp;
  logic [1:0]  prev_lane;
  logic [15:0] mem_buf [4];
  logic [15:0] wb_buf  [4];

  logic [3:0]  req;
  logic [3:0]  ld_mask;
  logic [2:0]  req_cnt;
  logic [1:0]  sel;
  logic        sel_ld;
  logic        issue;
  logic [3:0]  pend_next;

  function automatic logic [1:0] lowest(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  assign ld_mask = lane_is_load & lane_active;
  assign req     = (lane_is_load | lane_is_store) & lane_active;
  assign req_cnt = {2'b0, req[0]} + {2'b0, req[1]} + {2'b0, req[2]} + {2'b0, req[3]};

  always_comb begin
    sel       = lowest((state == SERVE) ? pending : req);
    sel_ld    = (state == SERVE) ? batch_ld[sel] : ld_mask[sel];
    pend_next = pending & ~onehot(sel);
    issue     = 1'b0;
    mem_stall = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req_cnt >= 3'd2) begin
            issue     = 1'b1;
            mem_stall = 1'b1;
          end else if (req_cnt == 3'd1 && !other_stall) begin
            issue = 1'b1;
          end
        end
        SERVE: begin
          issue     = 1'b1;
          mem_stall = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dmem.en    = issue;
    dmem.we    = issue & ~sel_ld;
    dmem.addr  = '0;
    dmem.wdata = '0;
    if (issue) begin
      dmem.addr = lane_addr[{sel, 4'b0000} +: ADDR_W];
      if (!sel_ld) dmem.wdata = lane_wdata[{sel, 4'b0000} +: 16];
    end
  end

  // Bypass lane reads the BRAM output live; it holds because no enable follows until the next issue.
  always_comb begin
    lane_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (!rst) lane_rdata[16*i +: 16] = wb_byp[i] ? dmem.rdata : wb_buf[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      batch_ld  <= '0;
      wb_byp    <= '0;
      prev_lane <= '0;
      for (int i = 0; i < 4; i++) begin
        mem_buf[i] <= '0;
        wb_buf[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req_cnt >= 3'd2) begin
            // Freeze the WB instruction's bypassed data before the batch reads overwrite the BRAM output.
            for (int i = 0; i < 4; i++) begin
              if (wb_byp[i]) wb_buf[i] <= dmem.rdata;
            end
            wb_byp    <= '0;
            pending   <= req & ~onehot(sel);
            batch_ld  <= ld_mask;
            prev_lane <= sel;
            state     <= SERVE;
          end else if (!other_stall) begin
            wb_byp <= (req_cnt == 3'd1 && ld_mask[sel]) ? onehot(sel) : 4'b0000;
          end
        end
        SERVE: begin
          mem_buf[prev_lane] <= dmem.rdata;
          prev_lane          <= sel;
          pending            <= pend_next;
          if (pend_next == 4'b0000) state <= DONE;
        end
        DONE: begin
          for (int i = 0; i < 4; i++) begin
            if (batch_ld[i]) wb_buf[i] <= (2'(i) == prev_lane) ? dmem.rdata : mem_buf[i];
          end
          if (!other_stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_ldst_unit.sv
// tb/tb_sm_ldst_unit.sv - randomized bench for sm_ldst_unit against a lane-ordered memory model
module tb_sm_ldst_unit;
  localparam int ADDR_W = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  lane_is_load = '0, lane_is_store = '0, lane_active = '0;
  logic [63:0] lane_addr = '0, lane_wdata = '0;
  logic        other_stall = 1'b0;
  logic        mem_stall;
  logic [63:0] lane_rdata;

  sm_ldst_unit_if #(.ADDR_W(ADDR_W)) dmem ();

  sm_ldst_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .lane_is_load(lane_is_load), .lane_is_store(lane_is_store), .lane_active(lane_active),
    .lane_addr(lane_addr), .lane_wdata(lane_wdata), .other_stall(other_stall),
    .mem_stall(mem_stall), .lane_rdata(lane_rdata), .dmem(dmem)
  );

  always #5 clk = ~clk;

  logic [15:0] bram [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) bram[pre_addr] <= pre_data;
    else if (dmem.en) begin
      if (dmem.we) bram[dmem.addr] <= dmem.wdata;
      else         dmem.rdata <= bram[dmem.addr];
    end
  end

  int          checks = 0;
  int          failures = 0;
  logic [15:0] ref_mem [0:63];
  logic [63:0] wb_exp_v = '0;
  logic [3:0]  wb_valid = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] lane_mask(input logic [3:0] m);
    logic [63:0] r = '0;
    for (int i = 0; i < 4; i++) if (m[i]) r[16*i +: 16] = 16'hFFFF;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [3:0] ld, input logic [3:0] st, input logic [3:0] act,
                       input logic [63:0] a, input logic [63:0] w, input logic os);
    lane_is_load = ld; lane_is_store = st; lane_active = act;
    lane_addr = a; lane_wdata = w; other_stall = os;
    #2;
  endtask

  task automatic check_prior(input string tag);
    logic [63:0] m = lane_mask(wb_valid);
    if (wb_valid != 4'b0000) check(tag, lane_rdata & m, wb_exp_v & m);
  endtask

  task automatic check_acc(input string tag, input logic [27:0] exp);
    logic [27:0] g = {dmem.en, dmem.we, dmem.addr, dmem.we ? dmem.wdata : 16'h0000};
    check(tag, {36'b0, g}, {36'b0, exp});
  endtask

  function automatic logic rnd(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  // One warp instruction from entering MEM until it advances into WB.
  task automatic run_instr(input logic [3:0] ld, input logic [3:0] st, input logic [3:0] act,
                           input logic [63:0] a, input logic [63:0] w,
                           input int stall_pct, input int done_hold);
    logic [3:0]  r = (ld | st) & act;
    logic [63:0] new_exp = '0;
    logic [27:0] acc[$];
    logic [9:0]  a10;
    logic        os;
    int          n;
    for (int i = 0; i < 4; i++) begin
      if (r[i]) begin
        a10 = a[16*i +: 10];
        if (ld[i]) begin
          new_exp[16*i +: 16] = ref_mem[a10[5:0]];
          acc.push_back({1'b1, 1'b0, a10, 16'h0000});
        end else begin
          ref_mem[a10[5:0]] = w[16*i +: 16];
          acc.push_back({1'b1, 1'b1, a10, w[16*i +: 16]});
        end
      end
    end
    n = acc.size();
    if (n >= 2) begin
      for (int k = 0; k < n; k++) begin
        apply(ld, st, act, a, w, rnd(stall_pct));
        check("batch_stall", {63'b0, mem_stall}, 64'd1);
        check_acc("batch_issue", acc[k]);
        check_prior("batch_wb_hold");
        step();
      end
      for (int d = 0; d < 40; d++) begin
        os = (d < done_hold) ? 1'b1 : (d >= 20) ? 1'b0 : rnd(stall_pct);
        if (d == 0) apply(ld, st, act, a, w, os);
        else apply(4'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, os);
        check("done_stall", {63'b0, mem_stall}, 64'd0);
        check("done_en", {63'b0, dmem.en}, 64'd0);
        if (d == 0) check_prior("done_wb_hold");
        else check("done_wb_new", lane_rdata & lane_mask(ld & act), new_exp & lane_mask(ld & act));
        step();
        if (!os) break;
      end
    end else begin
      for (int t = 0; t < 40; t++) begin
        os = (t >= 20) ? 1'b0 : rnd(stall_pct);
        apply(ld, st, act, a, w, os);
        check("fast_stall", {63'b0, mem_stall}, 64'd0);
        if (n == 1 && !os) check_acc("fast_issue", acc[0]);
        else check("fast_no_en", {63'b0, dmem.en}, 64'd0);
        check_prior("fast_wb_hold");
        step();
        if (!os) break;
      end
    end
    wb_valid = ld & act;
    wb_exp_v = new_exp;
  endtask

  function automatic logic [63:0] rand_addrs();
    logic [63:0] v;
    for (int i = 0; i < 4; i++) v[16*i +: 16] = {6'($urandom), 4'b0000, 6'($urandom_range(0, 63))};
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 16'($urandom);
    ref_mem[16'h10] = 16'hBEEF;
    ref_mem[0] = 16'h1111; ref_mem[1] = 16'h2222; ref_mem[2] = 16'h3333; ref_mem[3] = 16'h4444;

    step();
    apply(4'hF, 4'h0, 4'hF, 64'h0003_0002_0001_0004, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    check("rst_stall", {63'b0, mem_stall}, 64'd0);
    check("rst_dmem", {36'b0, dmem.en, dmem.we, dmem.addr, dmem.wdata}, 64'd0);
    check("rst_rdata", lane_rdata, 64'd0);
    apply(4'h0, 4'h0, 4'h0, 64'd0, 64'd0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      pre_we = 1'b1; pre_addr = 10'(i); pre_data = ref_mem[i];
      step();
    end
    pre_we = 1'b0;
    rst = 1'b0;

    run_instr(4'b0100, 4'b0000, 4'b0100, 64'h0000_0010_0000_0000, 64'd0, 0, 0);
    run_instr(4'b1111, 4'b0000, 4'b1111, 64'h0003_0002_0001_0000, 64'd0, 0, 0);
    run_instr(4'b1000, 4'b0001, 4'b1001, 64'h0005_0000_0000_0005, 64'h0000_0000_0000_00A5, 0, 0);
    run_instr(4'b0000, 4'b0110, 4'b0010, 64'h0000_0021_0020_0000, 64'h0000_1234_5678_0000, 0, 0);
    run_instr(4'b0001, 4'b0000, 4'b0001, 64'h0000_0000_0000_0010, 64'd0, 0, 0);
    run_instr(4'b1001, 4'b0000, 4'b1001, 64'h0003_0000_0000_0002, 64'd0, 0, 0);
    run_instr(4'b0110, 4'b0000, 4'b0110, 64'h0000_0001_0000_0000, 64'd0, 0, 3);
    run_instr(4'b0000, 4'b0000, 4'b0000, 64'd0, 64'd0, 0, 0);

    apply(4'hF, 4'h0, 4'hF, 64'h0003_0002_0001_0000, 64'd0, 1'b0);
    check("rstx_pre_stall", {63'b0, mem_stall}, 64'd1);
    step();
    rst = 1'b1;
    apply(4'hF, 4'h0, 4'hF, 64'h0003_0002_0001_0000, 64'd0, 1'b0);
    check("rstx_stall", {63'b0, mem_stall}, 64'd0);
    check("rstx_en", {63'b0, dmem.en}, 64'd0);
    check("rstx_rdata", lane_rdata, 64'd0);
    step();
    rst = 1'b0;
    apply(4'h0, 4'h0, 4'h0, 64'd0, 64'd0, 1'b0);
    check("rstx_idle_stall", {63'b0, mem_stall}, 64'd0);
    check("rstx_idle_rdata", lane_rdata, 64'd0);
    step();
    wb_valid = '0;
    run_instr(4'b0010, 4'b0000, 4'b0010, 64'h0000_0000_0010_0000, 64'd0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      run_instr(4'($urandom), 4'($urandom), 4'($urandom) | 4'($urandom), rand_addrs(),
                {$urandom, $urandom}, 30, int'($urandom_range(0, 2)));
    end
    run_instr(4'b0000, 4'b0000, 4'b0000, 64'd0, 64'd0, 0, 0);

    for (int i = 0; i < 64; i++) check("mem_final", {48'b0, bram[i]}, {48'b0, ref_mem[i]});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
